mxn_arb: RTL and testbench
==========================

MXN_ARB -- requirements
Module: mxn_arb

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (1..32).
REQ-002 Parameter NCH, default 8, number of input channels; legal values 2, 4, 8 or 16.
REQ-003 Parameter SELW, default 3, channel-index width; SHALL equal log2(NCH).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port din  input  NCH*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 Port din_valid  input  NCH  per-channel request, bit i for channel i.
REQ-008 Port din_ready  output  NCH  per-channel accept strobe, bit i for channel i.
REQ-009 Port mode  input  1  0 = direct select by sel, 1 = round-robin arbitration.
REQ-010 Port sel  input  SELW  channel index used when mode=0.
REQ-011 Port y  output  WIDTH  registered selected data.
REQ-012 Port y_ch  output  SELW  index of the channel that produced y.
REQ-013 Port y_valid  output  1  y/y_ch hold an undelivered word.
REQ-014 Port out_ready  input  1  downstream accepts y when high with y_valid.
REQ-015 Port xfer_cnt  output  8  count of completed output transfers, wraps 255->0.

Function
REQ-016 Output state machine SHALL have two states: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-017 Internal load = (state==EMPTY) | out_ready.
REQ-018 mode=0: candidate = sel; grant SHALL occur iff load & din_valid[sel].
REQ-019 mode=1: candidate = first i with din_valid[i]=1, scanning ptr, ptr+1, ... modulo NCH; grant iff load & any din_valid.
REQ-020 din_ready SHALL be combinational, one-hot on the granted channel, else all zeros.
REQ-021 On grant: y <= din[candidate], y_ch <= candidate, state -> FULL (1-cycle latency).
REQ-022 No grant and out_ready=1 in FULL: state -> EMPTY; y and y_ch SHALL hold their values.
REQ-023 FULL and out_ready=0: y, y_ch, state stable; din_ready all zeros.
REQ-024 Simultaneous drain and grant (FULL, out_ready=1, grant) SHALL transfer and reload in the same cycle, staying FULL.
REQ-025 Round-robin pointer ptr (SELW bits) SHALL update to (candidate+1) mod NCH only on a mode=1 grant; mode=0 grants SHALL leave it unchanged.
REQ-026 A mode or sel change SHALL affect only the next grant; the word held in y SHALL be unaffected.
REQ-027 xfer_cnt SHALL increment by 1 on each cycle with y_valid & out_ready.

Reset
REQ-028 When reset=1 at a clock edge: y=0, y_ch=0, y_valid=0 (EMPTY), ptr=0, xfer_cnt=0.
REQ-029 A held word at reset SHALL be discarded without a transfer being counted.
REQ-030 While reset=1, din_ready SHALL be all zeros.

Configuration
REQ-031 Macro MXN_ARB_PARITY_EN defined: add output y_par (1 bit), registered with y, equal to XOR of the loaded data; 0 at reset.
REQ-032 MXN_ARB_PARITY_EN undefined: y_par port absent; all other behaviour identical.

Verification
REQ-033 Reset, then mode=0, sel=5, din_valid=8'h20, ch5=4'hA, out_ready=1 -> next cycle y=4'hA, y_ch=5, y_valid=1; din_ready=8'h20 during the grant cycle.
REQ-034 mode=1, din_valid=8'hFF held, out_ready=1 for 10 cycles -> y_ch sequence 0,1,2,...,7,0,1; xfer_cnt reaches 9 one cycle after the 10th grant.
REQ-035 FULL with y=4'h3, out_ready=0 for 4 cycles, ch changing -> y stays 4'h3, din_ready=0; then out_ready=1 with a valid request -> reload in the same cycle with y_valid kept at 1.
REQ-036 mode=1, ptr=6, din_valid=8'h05 -> grant ch0 (wrap-around), then ch2, then ch0.
REQ-037 Reset asserted while FULL -> next cycle y_valid=0, xfer_cnt=0, ptr=0; with MXN_ARB_PARITY_EN, load 4'hB -> y_par=1.

Source files
------------

// File: rtl/mxn_arb.sv
// N-channel to one registered-output arbiter with direct-select and round-robin modes.
// Optional registered parity output y_par when MXN_ARB_PARITY_EN is defined.
module mxn_arb #(
    parameter int WIDTH = 4,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*WIDTH-1:0]  din,
    input  logic [NCH-1:0]        din_valid,
    output logic [NCH-1:0]        din_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      y,
    output logic [SELW-1:0]       y_ch,
    output logic                  y_valid,
    input  logic                  out_ready,
    output logic [7:0]            xfer_cnt
`ifdef MXN_ARB_PARITY_EN
    ,
    output logic                  y_par
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_cand;
    logic [SELW-1:0] idx;
    logic [SELW-1:0] cand;
    logic            rr_any;
    logic            load;
    logic            grant;
    logic [WIDTH-1:0] ch [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch[i] = din[i*WIDTH +: WIDTH];
    end

    // Scan from farthest to nearest so the lowest offset from ptr wins;
    // SELW-bit addition wraps modulo NCH for free.
    always_comb begin
        rr_cand = '0;
        rr_any  = 1'b0;
        idx     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + SELW'(k);
            if (din_valid[idx]) begin
                rr_cand = idx;
                rr_any  = 1'b1;
            end
        end
    end

    assign load    = (state == EMPTY) | out_ready;
    assign cand    = mode ? rr_cand : sel;
    assign grant   = !reset && load && (mode ? rr_any : din_valid[sel]);
    assign y_valid = (state == FULL);

    always_comb begin
        din_ready = '0;
        if (grant) din_ready[cand] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            y        <= '0;
            y_ch     <= '0;
            ptr      <= '0;
            xfer_cnt <= '0;
`ifdef MXN_ARB_PARITY_EN
            y_par    <= 1'b0;
`endif
        end else begin
            if (y_valid && out_ready) xfer_cnt <= xfer_cnt + 8'd1;
            if (grant) begin
                y     <= ch[cand];
                y_ch  <= cand;
                state <= FULL;
                if (mode) ptr <= cand + SELW'(1);
`ifdef MXN_ARB_PARITY_EN
                y_par <= ^ch[cand];
`endif
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_mxn_arb.sv
// Scoreboard bench for mxn_arb: a reference model predicts grants, queues the
// expected word per grant and compares it when the DUT registers its output.
module tb_mxn_arb;

    localparam int WIDTH = 4;
    localparam int NCH   = 8;
    localparam int SELW  = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       din_valid;
    logic [NCH-1:0]       din_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     y;
    logic [SELW-1:0]      y_ch;
    logic                 y_valid;
    logic                 out_ready;
    logic [7:0]           xfer_cnt;
`ifdef MXN_ARB_PARITY_EN
    logic                 y_par;
`endif

    mxn_arb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .mode      (mode),
        .sel       (sel),
        .y         (y),
        .y_ch      (y_ch),
        .y_valid   (y_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
`ifdef MXN_ARB_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SELW-1:0]  c;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int               m_ptr;
    logic             m_full;
    logic [7:0]       m_cnt;
    logic [WIDTH-1:0] m_y;
    logic [SELW-1:0]  m_ych;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(int i, logic [WIDTH-1:0] v);
        din[i*WIDTH +: WIDTH] = v;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        int               c;
        logic             g;
        logic             found;
        logic [NCH-1:0]   er;
        logic [WIDTH-1:0] gd;
        exp_t             e;
        #1;
        c     = int'(sel);
        g     = 1'b0;
        found = 1'b0;
        if (!reset) begin
            if (!mode) begin
                g = (!m_full || out_ready) && din_valid[sel];
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    int id;
                    id = (m_ptr + k) % NCH;
                    if (!found && din_valid[id]) begin
                        found = 1'b1;
                        c     = id;
                    end
                end
                g = found && (!m_full || out_ready);
            end
        end
        er = '0;
        if (g) er[c] = 1'b1;
        chk("din_ready", 32'(din_ready), 32'(er));
        gd = din[c*WIDTH +: WIDTH];
        if (g) sb.push_back({gd, SELW'(c)});
        @(posedge clk);
        #1;
        if (reset) begin
            m_full = 1'b0;
            m_cnt  = '0;
            m_ptr  = 0;
            m_y    = '0;
            m_ych  = '0;
        end else begin
            if (m_full && out_ready) m_cnt = m_cnt + 8'd1;
            if (g) begin
                m_full = 1'b1;
                m_y    = gd;
                m_ych  = SELW'(c);
                if (mode) m_ptr = (c + 1) % NCH;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
        if (g) begin
            e = sb.pop_front();
            chk("sb_y", 32'(y), 32'(e.d));
            chk("sb_ych", 32'(y_ch), 32'(e.c));
        end
        chk("y", 32'(y), 32'(m_y));
        chk("y_ch", 32'(y_ch), 32'(m_ych));
        chk("y_valid", 32'(y_valid), 32'(m_full));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`ifdef MXN_ARB_PARITY_EN
        chk("y_par", 32'(y_par), 32'(^m_y));
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        din       = '0;
        din_valid = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        m_ptr     = 0;
        m_full    = 1'b0;
        m_cnt     = '0;
        m_y       = '0;
        m_ych     = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_valid", 32'(y_valid), 32'h0);
        chk("rst_cnt", 32'(xfer_cnt), 32'h0);
        reset = 1'b0;

        // direct select of channel 5
        mode = 1'b0; sel = 3'd5; din_valid = 8'h20; out_ready = 1'b1;
        set_ch(5, 4'hA);
        tick();
        chk("dir_y", 32'(y), 32'hA);
        chk("dir_ych", 32'(y_ch), 32'd5);
        chk("dir_valid", 32'(y_valid), 32'd1);

        // round-robin across all requesters
        do_reset();
        mode = 1'b1; din_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, WIDTH'(i + 3));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr_seq", 32'(y_ch), 32'(i % NCH));
        end
        chk("rr_cnt9", 32'(xfer_cnt), 32'd9);
        din_valid = '0;
        tick();
        chk("rr_cnt10", 32'(xfer_cnt), 32'd10);

        // backpressure holds the word, then drain+reload
        mode = 1'b0; sel = 3'd2; din_valid = 8'h04; out_ready = 1'b1;
        set_ch(2, 4'h3);
        tick();
        out_ready = 1'b0; din_valid = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            set_ch(2, WIDTH'(i + 5));
            sel = SELW'(i);
            tick();
            chk("hold_y", 32'(y), 32'h3);
        end
        out_ready = 1'b1; sel = 3'd2; set_ch(2, 4'h9);
        tick();
        chk("reload_y", 32'(y), 32'h9);
        chk("reload_valid", 32'(y_valid), 32'd1);

        // wrap-around from ptr=6
        do_reset();
        mode = 1'b1; din_valid = 8'h20;
        tick();
        din_valid = 8'h05;
        set_ch(0, 4'h1); set_ch(2, 4'h2);
        tick(); chk("wrap0", 32'(y_ch), 32'd0);
        tick(); chk("wrap2", 32'(y_ch), 32'd2);
        tick(); chk("wrap0b", 32'(y_ch), 32'd0);

        // direct grant leaves ptr (=1) unchanged
        mode = 1'b0; sel = 3'd3; din_valid = 8'h08;
        tick();
        mode = 1'b1; din_valid = 8'hFF;
        tick(); chk("ptr_kept", 32'(y_ch), 32'd1);

        // drain without grant keeps y
        din_valid = '0;
        tick();
        chk("drain_valid", 32'(y_valid), 32'd0);

        // reset while FULL
        mode = 1'b1; din_valid = 8'h10; set_ch(4, 4'hB);
        tick();
        out_ready = 1'b0;
        tick();
        din_valid = 8'hFF; out_ready = 1'b1;
        do_reset();
        chk("rstf_valid", 32'(y_valid), 32'd0);
        chk("rstf_cnt", 32'(xfer_cnt), 32'd0);
        din_valid = 8'h10;
        tick(); chk("rstf_ptr", 32'(y_ch), 32'd4);
        din_valid = 8'hFF;
        tick(); chk("rstf_next", 32'(y_ch), 32'd5);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = SELW'($urandom_range(0, NCH - 1));
            din_valid = NCH'($urandom);
            din       = (NCH*WIDTH)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 29) == 0);
            tick();
        end
        reset = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
